// File: rtl/jpeg_rle_pkg.sv
// Shared types and helpers for the JPEG zero-run-length / size-category encoder.
package jpeg_rle_pkg;

    localparam int unsigned RUN_W    = 4;
    localparam int unsigned ZRL_RUN  = 15;
    localparam int unsigned MAG_W    = 33;
    localparam int unsigned LEN_W    = 6;

    typedef enum logic [1:0] {
        ACCEPT,
        EMIT_ZRL,
        EMIT_SYM,
        EMIT_EOB
    } rle_state_t;

    // size/amp travel beside this header at the instance's own COEF_W/SIZE_W
    typedef struct packed {
        logic [RUN_W-1:0] run;
        logic             dc;
        logic             eob;
        logic             zrl;
        logic             blk_end;
    } rle_sym_t;

    function automatic logic [LEN_W-1:0] size_cat(input logic [MAG_W-1:0] mag);
        logic [LEN_W-1:0] len;
        len = '0;
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (mag[i]) len = LEN_W'(i + 1);
        end
        return len;
    endfunction

endpackage

// File: rtl/jpeg_size_cat.sv
// Combinational JPEG size category and amplitude bits for one signed coefficient.
module jpeg_size_cat
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int SIZE_W = 4
) (
    input  logic signed [COEF_W-1:0] coef,
    output logic        [SIZE_W-1:0] size,
    output logic        [COEF_W-1:0] amp
);

    logic signed [COEF_W:0]   wide;
    logic        [COEF_W:0]   mag;
    logic        [COEF_W-1:0] raw;
    logic        [LEN_W-1:0]  len;

    always_comb begin
        wide = {coef[COEF_W-1], coef};
        mag  = coef[COEF_W-1] ? -wide : wide;
        // the most-negative value wraps to 0111..1, which is exactly its masked amplitude
        raw  = coef[COEF_W-1] ? coef - COEF_W'(1) : coef;
        len  = size_cat(MAG_W'(mag));
        size = SIZE_W'(len);
        amp  = '0;
        for (int unsigned i = 0; i < COEF_W; i++) begin
            amp[i] = raw[i] & (i < 32'(len));
        end
    end

endmodule

// File: rtl/jpeg_rle_encoder.sv
// Streaming zero-run / size-category encoder for zigzag JPEG blocks with deferred ZRL and EOB.
// Optional per-block symbol statistics are enabled by defining JPEG_RLE_STATS_EN.
module jpeg_rle_encoder
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W    = 12,
    parameter int BLOCK_LEN = 64,
    parameter int SIZE_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [RUN_W-1:0]  out_run,
    output logic        [SIZE_W-1:0] out_size,
    output logic        [COEF_W-1:0] out_amp,
    output logic                     out_dc,
    output logic                     out_eob,
    output logic                     out_zrl,
`ifdef JPEG_RLE_STATS_EN
    output logic        [6:0]        stat_syms,
    output logic        [2:0]        stat_zrls,
`endif
    output logic                     out_blk_end
);

    localparam int               IDX_W      = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int               ZC_W       = $clog2(BLOCK_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BLOCK_LEN - 1);
    localparam logic             LAST_IS_DC = (BLOCK_LEN == 1);

    rle_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [ZC_W-1:0]   zcnt;
    logic [SIZE_W-1:0] cur_size, pend_size, sym_size;
    logic [COEF_W-1:0] cur_amp, pend_amp, sym_amp;
    logic              pend_last;
    rle_sym_t          sym_hdr;
    logic              sym_valid;
    logic              slot_free, in_fire, is_last;

    function automatic rle_sym_t hdr(input logic [RUN_W-1:0] run, input logic dc,
                                     input logic eob, input logic zrl, input logic blk_end);
        rle_sym_t s;
        s.run     = run;
        s.dc      = dc;
        s.eob     = eob;
        s.zrl     = zrl;
        s.blk_end = blk_end;
        return s;
    endfunction

    jpeg_size_cat #(
        .COEF_W(COEF_W),
        .SIZE_W(SIZE_W)
    ) u_size_cat (
        .coef(in_coef),
        .size(cur_size),
        .amp (cur_amp)
    );

    always_comb begin
        slot_free = !sym_valid || out_ready;
        in_ready  = !rst && (state == ACCEPT) && slot_free;
        in_fire   = in_valid && in_ready;
        is_last   = (idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCEPT;
            idx       <= '0;
            zcnt      <= '0;
            pend_size <= '0;
            pend_amp  <= '0;
            pend_last <= 1'b0;
            sym_hdr   <= '0;
            sym_size  <= '0;
            sym_amp   <= '0;
            sym_valid <= 1'b0;
        end else begin
            if (sym_valid && out_ready) sym_valid <= 1'b0;
            unique case (state)
                ACCEPT: if (in_fire) begin
                    idx <= is_last ? '0 : idx + IDX_W'(1);
                    if (idx == '0) begin
                        sym_hdr   <= hdr('0, 1'b1, 1'b0, 1'b0, LAST_IS_DC);
                        sym_size  <= cur_size;
                        sym_amp   <= cur_amp;
                        sym_valid <= 1'b1;
                        zcnt      <= '0;
                    end else if (in_coef == '0) begin
                        if (is_last) begin
                            state <= EMIT_EOB;
                            zcnt  <= '0;
                        end else begin
                            zcnt <= zcnt + ZC_W'(1);
                        end
                    end else if (32'(zcnt) < 16) begin
                        sym_hdr   <= hdr(RUN_W'(zcnt), 1'b0, 1'b0, 1'b0, is_last);
                        sym_size  <= cur_size;
                        sym_amp   <= cur_amp;
                        sym_valid <= 1'b1;
                        zcnt      <= '0;
                    end else begin
                        pend_size <= cur_size;
                        pend_amp  <= cur_amp;
                        pend_last <= is_last;
                        state     <= EMIT_ZRL;
                    end
                end
                EMIT_ZRL: if (slot_free) begin
                    sym_hdr   <= hdr(RUN_W'(ZRL_RUN), 1'b0, 1'b0, 1'b1, 1'b0);
                    sym_size  <= '0;
                    sym_amp   <= '0;
                    sym_valid <= 1'b1;
                    zcnt      <= zcnt - ZC_W'(16);
                    if (32'(zcnt) < 32) state <= EMIT_SYM;
                end
                EMIT_SYM: if (slot_free) begin
                    sym_hdr   <= hdr(RUN_W'(zcnt), 1'b0, 1'b0, 1'b0, pend_last);
                    sym_size  <= pend_size;
                    sym_amp   <= pend_amp;
                    sym_valid <= 1'b1;
                    zcnt      <= '0;
                    state     <= ACCEPT;
                end
                EMIT_EOB: if (slot_free) begin
                    sym_hdr   <= hdr('0, 1'b0, 1'b1, 1'b0, 1'b1);
                    sym_size  <= '0;
                    sym_amp   <= '0;
                    sym_valid <= 1'b1;
                    state     <= ACCEPT;
                end
            endcase
        end
    end

    always_comb begin
        out_valid   = sym_valid;
        out_run     = sym_hdr.run;
        out_size    = sym_size;
        out_amp     = sym_amp;
        out_dc      = sym_hdr.dc;
        out_eob     = sym_hdr.eob;
        out_zrl     = sym_hdr.zrl;
        out_blk_end = sym_hdr.blk_end;
    end

`ifdef JPEG_RLE_STATS_EN
    logic [6:0] cnt_syms;
    logic [2:0] cnt_zrls;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_syms  <= '0;
            cnt_zrls  <= '0;
            stat_syms <= '0;
            stat_zrls <= '0;
        end else if (sym_valid && out_ready) begin
            if (sym_hdr.blk_end) begin
                stat_syms <= cnt_syms + 7'd1;
                stat_zrls <= cnt_zrls + 3'(sym_hdr.zrl);
                cnt_syms  <= '0;
                cnt_zrls  <= '0;
            end else begin
                cnt_syms <= cnt_syms + 7'd1;
                cnt_zrls <= cnt_zrls + 3'(sym_hdr.zrl);
            end
        end
    end
`endif

endmodule
